// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC redirect sequencer: orders branch redirects behind the MIPS delay slot and buffers them across stalls.
// Optional statistics counters are built when FETCH_REDIRECT_STATS_EN is defined.
module fetch_redirect_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic              except_flush,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              br_ds_fetched,
  input  logic              ds_fetch_done,
  output logic              hold_pc,
  output logic              jump,
  output logic [ADDR_W-1:0] jump_to,
  output logic              kill_fetch,
  output logic              busy,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  // state      | meaning
  // ST_IDLE    | no redirect outstanding
  // ST_WAIT_DS | target latched, delay-slot fetch still outstanding
  // ST_PENDING | ready to issue, blocked by stall_req
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_DS = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              kill_q, kill_d;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    jump    = 1'b0;
    jump_to = tgt_q;
    hold_pc = stall_req & ~except_flush;
    if (except_flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (br_valid) begin
            if (br_ds_fetched && !stall_req) begin
              jump    = 1'b1;
              jump_to = br_target;
            end else begin
              tgt_d   = br_target;
              state_d = br_ds_fetched ? ST_PENDING : ST_WAIT_DS;
            end
          end
        end
        ST_WAIT_DS: begin
          if (ds_fetch_done) begin
            if (stall_req) begin
              state_d = ST_PENDING;
            end else begin
              jump    = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_PENDING: begin
          if (!stall_req) begin
            jump    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    kill_d = jump & ~except_flush;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      kill_q  <= kill_d;
    end
  end

  assign kill_fetch = kill_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef FETCH_REDIRECT_STATS_EN
  // A branch is lost when a new one arrives while busy, or a flush discards the held one.
  logic             drop_evt;
  logic [CNT_W-1:0] redirect_cnt_q, drop_cnt_q;

  assign drop_evt = (state_q != ST_IDLE) & (except_flush | br_valid);

  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      if (jump)     redirect_cnt_q <= redirect_cnt_q + 1'b1;
      if (drop_evt) drop_cnt_q     <= drop_cnt_q + 1'b1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign drop_cnt     = drop_cnt_q;
`else
  assign redirect_cnt = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl; inputs change 1ns after each rising edge.
module tb_fetch_redirect_ctrl;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_req, except_flush, br_valid, br_ds_fetched, ds_fetch_done;
  logic [ADDR_W-1:0] br_target;
  logic              hold_pc, jump, kill_fetch, busy;
  logic [ADDR_W-1:0] jump_to;
  logic [CNT_W-1:0]  redirect_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_redir = 0;
  int exp_drop = 0;

  fetch_redirect_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .except_flush(except_flush),
    .br_valid(br_valid), .br_target(br_target), .br_ds_fetched(br_ds_fetched),
    .ds_fetch_done(ds_fetch_done), .hold_pc(hold_pc), .jump(jump), .jump_to(jump_to),
    .kill_fetch(kill_fetch), .busy(busy), .redirect_cnt(redirect_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic bv, input logic [ADDR_W-1:0] t,
                       input logic dsf, input logic dsd);
    stall_req = s; except_flush = f; br_valid = bv; br_target = t;
    br_ds_fetched = dsf; ds_fetch_done = dsd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0);
    tick(); tick();
    checks++; if (hold_pc !== 1'b0) begin errors++; $display("FAIL reset_hold got %b exp 0", hold_pc); end
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL reset_jump got %b exp 0", jump); end
    checks++; if (jump_to !== 32'h0) begin errors++; $display("FAIL reset_jump_to got %h exp 0", jump_to); end
    checks++; if (kill_fetch !== 1'b0) begin errors++; $display("FAIL reset_kill got %b exp 0", kill_fetch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (redirect_cnt !== '0 || drop_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", redirect_cnt, drop_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_immediate();
    drive(0, 0, 1, 32'hBFC0_0100, 1, 0);
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL imm_jump got %b exp 1", jump); end
    checks++; if (jump_to !== 32'hBFC0_0100) begin errors++; $display("FAIL imm_target got %h exp bfc00100", jump_to); end
    exp_redir++;
    tick();
    drive(0, 0, 0, 32'h0, 0, 0);
    checks++; if (kill_fetch !== 1'b1) begin errors++; $display("FAIL imm_kill got %b exp 1", kill_fetch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL imm_busy got %b exp 0", busy); end
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL imm_jump_once got %b exp 0", jump); end
    tick();
    checks++; if (kill_fetch !== 1'b0) begin errors++; $display("FAIL imm_kill_pulse got %b exp 0", kill_fetch); end
  endtask

  task automatic test_ds_wait();
    drive(0, 0, 1, 32'h8000_0040, 0, 0);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL ds_jump0 got %b exp 0", jump); end
    tick();
    for (int c = 1; c <= 2; c++) begin
      drive(0, 0, 0, 32'h0, 0, 0);
      checks++; if (jump !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL ds_wait_c%0d got jump=%b busy=%b exp 0/1", c, jump, busy); end
      tick();
    end
    drive(0, 0, 0, 32'h0, 0, 1);
    checks++; if (jump !== 1'b1 || jump_to !== 32'h8000_0040) begin
      errors++; $display("FAIL ds_issue got %b/%h exp 1/80000040", jump, jump_to); end
    exp_redir++;
    tick();
    drive(0, 0, 0, 32'h0, 0, 0);
    checks++; if (kill_fetch !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ds_kill got kill=%b busy=%b exp 1/0", kill_fetch, busy); end
  endtask

  task automatic test_ds_same_cycle();
    drive(0, 0, 1, 32'h8000_0080, 0, 1);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL dssame_jump got %b exp 0", jump); end
    tick();
    drive(0, 0, 0, 32'h0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dssame_busy got %b exp 1", busy); end
    tick();
    drive(0, 0, 0, 32'h0, 0, 1);
    checks++; if (jump !== 1'b1 || jump_to !== 32'h8000_0080) begin
      errors++; $display("FAIL dssame_issue got %b/%h exp 1/80000080", jump, jump_to); end
    exp_redir++;
    tick();
    drive(0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_stall();
    drive(1, 0, 1, 32'h8000_1000, 1, 0);
    checks++; if (hold_pc !== 1'b1 || jump !== 1'b0) begin
      errors++; $display("FAIL stall_c0 got hold=%b jump=%b exp 1/0", hold_pc, jump); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1, 0, 0, 32'h0, 0, 0);
      checks++; if (hold_pc !== 1'b1 || jump !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_c%0d got hold=%b jump=%b busy=%b exp 1/0/1", c, hold_pc, jump, busy); end
      tick();
    end
    drive(0, 0, 0, 32'h0, 0, 0);
    checks++; if (jump !== 1'b1 || jump_to !== 32'h8000_1000 || hold_pc !== 1'b0) begin
      errors++; $display("FAIL stall_release got %b/%h/%b exp 1/80001000/0", jump, jump_to, hold_pc); end
    exp_redir++;
    tick();
    checks++; if (kill_fetch !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_kill got kill=%b busy=%b exp 1/0", kill_fetch, busy); end
  endtask

  task automatic test_flush();
    drive(1, 0, 1, 32'h8000_2000, 1, 0);
    tick();
    drive(1, 1, 0, 32'h0, 0, 0);
    checks++; if (hold_pc !== 1'b0 || jump !== 1'b0) begin
      errors++; $display("FAIL flush_out got hold=%b jump=%b exp 0/0", hold_pc, jump); end
    exp_drop++;
    tick();
    drive(0, 0, 0, 32'h0, 0, 0);
    checks++; if (busy !== 1'b0 || kill_fetch !== 1'b0 || jump !== 1'b0) begin
      errors++; $display("FAIL flush_idle got busy=%b kill=%b jump=%b exp 0/0/0", busy, kill_fetch, jump); end
`ifdef FETCH_REDIRECT_STATS_EN
    checks++; if (drop_cnt !== CNT_W'(exp_drop) || redirect_cnt !== CNT_W'(exp_redir)) begin
      errors++; $display("FAIL flush_cnt got %0d/%0d exp %0d/%0d", redirect_cnt, drop_cnt, exp_redir, exp_drop); end
`else
    checks++; if (drop_cnt !== '0 || redirect_cnt !== '0) begin
      errors++; $display("FAIL flush_cnt got %0d/%0d exp 0/0", redirect_cnt, drop_cnt); end
`endif
    tick();
  endtask

  task automatic test_dropped();
    drive(0, 0, 1, 32'h8000_3000, 0, 0);
    tick();
    drive(0, 0, 1, 32'hDEAD_BEE0, 1, 0);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL drop_jump got %b exp 0", jump); end
    exp_drop++;
    tick();
    drive(1, 0, 0, 32'h0, 0, 1);
    checks++; if (jump !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_ds_stall got jump=%b busy=%b exp 0/1", jump, busy); end
    tick();
    drive(0, 0, 0, 32'h0, 0, 0);
    checks++; if (jump !== 1'b1 || jump_to !== 32'h8000_3000) begin
      errors++; $display("FAIL drop_target got %b/%h exp 1/80003000", jump, jump_to); end
    exp_redir++;
    tick();
`ifdef FETCH_REDIRECT_STATS_EN
    checks++; if (drop_cnt !== CNT_W'(exp_drop) || redirect_cnt !== CNT_W'(exp_redir)) begin
      errors++; $display("FAIL drop_cnt got %0d/%0d exp %0d/%0d", redirect_cnt, drop_cnt, exp_redir, exp_drop); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 32'h8000_4000, 1, 0);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b exp 1", busy); end
    rst = 1'b0;
    drive(1, 0, 0, 32'h0, 0, 0);
    tick();
    checks++; if (busy !== 1'b0 || jump !== 1'b0 || kill_fetch !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got busy=%b jump=%b kill=%b exp 0/0/0", busy, jump, kill_fetch); end
    checks++; if (redirect_cnt !== '0 || drop_cnt !== '0) begin
      errors++; $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", redirect_cnt, drop_cnt); end
    rst = 1'b1;
    tick();
    drive(0, 0, 0, 32'h0, 0, 0);
    checks++; if (jump !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_nojump got jump=%b busy=%b exp 0/0", jump, busy); end
    tick();
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_ds_wait();
    test_ds_same_cycle();
    test_stall();
    test_flush();
    test_dropped();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences all PC redirects into the fetch-stage PC register; drives its hold_pc, jump and jump_to inputs.
- Sources: downstream fetch stall, exception flush, and EX-stage branch/jump resolution.
- Enforces MIPS delay-slot ordering: a branch redirect is never issued before the delay-slot instruction has been fetched.
- Buffers a resolved redirect across stalls, because the PC register ignores jump while hold_pc=1.

Parameters:
- ADDR_W, 32, instruction address width.
- CNT_W, 32, width of the statistics counters (used only under the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (0 = reset)
- stall_req  in  1  fetch cannot accept a new PC this cycle (icache miss / inst buffer full)
- except_flush  in  1  exception/ERET flush; the PC register redirects on it directly
- br_valid  in  1  single-cycle pulse: branch/jump resolved taken in EX
- br_target  in  ADDR_W  redirect target, valid with br_valid
- br_ds_fetched  in  1  with br_valid: delay slot already fetched
- ds_fetch_done  in  1  pulse: a pending delay-slot fetch has completed
- hold_pc  out  1  to the PC register
- jump  out  1  to the PC register; combinational
- jump_to  out  ADDR_W  to the PC register
- kill_fetch  out  1  registered pulse: squash wrong-path fetch in flight
- busy  out  1  redirect pending (state != ST_IDLE)
- redirect_cnt  out  CNT_W  optional feature only
- drop_cnt  out  CNT_W  optional feature only

Behaviour:
- States: ST_IDLE, ST_WAIT_DS (target latched, delay slot outstanding), ST_PENDING (ready to issue, blocked by stall).
- Internal registers: tgt_q[ADDR_W], state, kill_q.
- Reset (rst=0 at clk edge): state=ST_IDLE, tgt_q=0, kill_q=0. Outputs during and after reset, until inputs change: hold_pc=0, jump=0, jump_to=0, kill_fetch=0, busy=0, counters=0.
- hold_pc = stall_req & ~except_flush.
- jump, combinational, asserted only when except_flush=0 and stall_req=0, in exactly one of these cases:
  - a) ST_IDLE & br_valid & br_ds_fetched; jump_to=br_target.
  - b) ST_WAIT_DS & ds_fetch_done; jump_to=tgt_q.
  - c) ST_PENDING; jump_to=tgt_q.
- jump_to=tgt_q whenever jump=0 (no X on the bus).
- Transitions, in priority order:
  - except_flush=1: next=ST_IDLE regardless of state or other inputs. Any pending branch is discarded; jump=0 that cycle.
  - ST_IDLE, br_valid & br_ds_fetched & stall_req: latch tgt_q, ->ST_PENDING.
  - ST_IDLE, br_valid & ~br_ds_fetched: latch tgt_q, ->ST_WAIT_DS. Jump is never issued the same cycle, even if ds_fetch_done=1 (ds_fetch_done in ST_IDLE is ignored).
  - ST_IDLE, jump issued (case a): stay ST_IDLE.
  - ST_WAIT_DS, ds_fetch_done & ~stall_req: issue jump, ->ST_IDLE.
  - ST_WAIT_DS, ds_fetch_done & stall_req: ->ST_PENDING.
  - ST_WAIT_DS, otherwise: hold.
  - ST_PENDING, ~stall_req: issue jump, ->ST_IDLE. Otherwise hold.
- br_valid while state != ST_IDLE: dropped (wrong path); tgt_q unchanged.
- kill_q <= jump (one-cycle pulse the cycle after each issued jump); kill_fetch=kill_q. kill_q is cleared by except_flush (the flush already squashes fetch).
- Each resolved branch produces exactly one jump pulse; jump never coincides with hold_pc=1.
- busy = (state != ST_IDLE).

Optional Feature:
- Macro FETCH_REDIRECT_STATS_EN.
- Defined:
  - redirect_cnt increments on every cycle with jump=1.
  - drop_cnt increments on every dropped br_valid and on every pending branch discarded by except_flush.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- Immediate redirect: IDLE, br_valid=1, br_ds_fetched=1, br_target=0xBFC0_0100, stall_req=0 -> same cycle jump=1, jump_to=0xBFC0_0100; next cycle kill_fetch=1, busy=0.
- Delay-slot wait: br_valid, br_ds_fetched=0, target 0x8000_0040; ds_fetch_done on cycle +3 -> jump=0 on cycles +1..+2, jump=1 with jump_to=0x8000_0040 on cycle +3, kill_fetch on +4.
- Stall buffering: target 0x8000_1000, stall_req=1 for 4 cycles -> hold_pc=1, jump=0, busy=1 throughout; jump=1 on the first cycle stall_req=0.
- Flush priority: ST_PENDING with tgt 0x8000_2000, except_flush=1 with stall_req=1 -> hold_pc=0, jump=0; next cycle state ST_IDLE; drop_cnt=1 if stats enabled.
- Dropped branch: in ST_WAIT_DS, second br_valid target 0xDEAD_BEE0 -> tgt_q unchanged, the later jump goes to the original target.
- Reset mid-operation: rst=0 while ST_PENDING -> next cycle busy=0, jump=0, kill_fetch=0, counters=0; a held stall produces no jump after reset release.
